// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - Shared BCD digit limits and types for the clock datapath.
package clock_pkg;
    localparam int         BCD_W            = 4;
    localparam logic [3:0] UNITS_MAX        = 4'd9;
    localparam logic [3:0] TENS60_MAX       = 4'd5;
    localparam logic [3:0] HOUR_TENS_MAX    = 4'd2;
    localparam logic [3:0] HOUR23_UNITS_MAX = 4'd3;

    typedef logic [BCD_W-1:0] bcd_t;
endpackage

// File: rtl/bcd60_counter.sv
// rtl/bcd60_counter.sv - Two-digit BCD 00..59 counter with combinational wrap carry.
module bcd60_counter
    import clock_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output bcd_t tens,
    output bcd_t units,
    output logic carry
);
    bcd_t tens_q, tens_d;
    bcd_t units_q, units_d;
    logic at_max;

    assign at_max = (tens_q == TENS60_MAX) && (units_q == UNITS_MAX);
    assign carry  = inc && at_max;
    assign tens   = tens_q;
    assign units  = units_q;

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (clear) begin
            tens_d  = '0;
            units_d = '0;
        end else if (inc) begin
            if (units_q == UNITS_MAX) begin
                units_d = '0;
                tens_d  = (tens_q == TENS60_MAX) ? '0 : tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end
endmodule

// File: rtl/min_sec_counter.sv
// rtl/min_sec_counter.sv - 1 s prescaler, BCD seconds/minutes and hour-advance pulse.
module min_sec_counter
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    input  logic adj_min,
    input  logic adj_hour,
    output bcd_t sec_h,
    output bcd_t sec_l,
    output bcd_t min_h,
    output bcd_t min_l,
    output logic add_hour_l,
    output logic sec_tick
);
    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          sec_tick_q, sec_tick_d;
    logic          add_hour_q, add_hour_d;
    logic          tick;
    logic          sec_carry, min_carry, min_inc, hour_req;

    assign tick = en && (presc_q == PRESC_LAST);

    bcd60_counter u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (tick),
        .tens  (sec_h),
        .units (sec_l),
        .carry (sec_carry)
    );

    // Seconds carry and manual adjust merge into one increment, so a coincidence yields +1.
    assign min_inc  = sec_carry || adj_min;
    assign hour_req = sec_carry && min_carry;

    bcd60_counter u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (min_inc),
        .tens  (min_h),
        .units (min_l),
        .carry (min_carry)
    );

    always_comb begin
        presc_d    = presc_q;
        sec_tick_d = 1'b0;
        add_hour_d = 1'b0;
        if (clear) begin
            presc_d = '0;
        end else begin
            if (en) begin
                presc_d = tick ? '0 : presc_q + PW'(1);
            end
            sec_tick_d = tick;
            add_hour_d = hour_req || adj_hour;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
            add_hour_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_tick_q <= sec_tick_d;
            add_hour_q <= add_hour_d;
        end
    end

    assign sec_tick   = sec_tick_q;
    assign add_hour_l = add_hour_q;
endmodule

// File: tb/tb_min_sec_counter.sv
// tb/tb_min_sec_counter.sv - Scoreboard bench for min_sec_counter against a seconds-of-hour model.
module tb_min_sec_counter;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       en = 1'b0;
    logic       adj_min = 1'b0;
    logic       adj_hour = 1'b0;
    logic [3:0] sec_h, sec_l, min_h, min_l;
    logic       add_hour_l, sec_tick;

    min_sec_counter #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .en         (en),
        .adj_min    (adj_min),
        .adj_hour   (adj_hour),
        .sec_h      (sec_h),
        .sec_l      (sec_l),
        .min_h      (min_h),
        .min_l      (min_l),
        .add_hour_l (add_hour_l),
        .sec_tick   (sec_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sh;
        logic [3:0] sl;
        logic [3:0] mh;
        logic [3:0] ml;
        logic       tick;
        logic       addh;
    } obs_t;

    obs_t exp_q[$];
    int   m_secs  = 0;
    int   m_presc = 0;
    bit   m_tick  = 0;
    bit   m_addh  = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic obs_t mk(int sh, int sl, int mh, int ml, bit t, bit a);
        obs_t o;
        o.sh = 4'(sh); o.sl = 4'(sl); o.mh = 4'(mh); o.ml = 4'(ml);
        o.tick = t; o.addh = a;
        return o;
    endfunction

    function automatic obs_t model_obs();
        return mk((m_secs % 60) / 10, m_secs % 10, m_secs / 600, (m_secs / 60) % 10, m_tick, m_addh);
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.sh = sec_h; o.sl = sec_l; o.mh = min_h; o.ml = min_l;
        o.tick = sec_tick; o.addh = add_hour_l;
        return o;
    endfunction

    function automatic void check(string name, obs_t got, obs_t want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s @%0t: got %0h%0h:%0h%0h tick=%0b add_hour=%0b, expected %0h%0h:%0h%0h tick=%0b add_hour=%0b",
                      name, $time, got.mh, got.ml, got.sh, got.sl, got.tick, got.addh,
                      want.mh, want.ml, want.sh, want.sl, want.tick, want.addh);
    endfunction

    task automatic model_reset();
        m_secs = 0; m_presc = 0; m_tick = 0; m_addh = 0;
    endtask

    // Time is held as seconds-of-hour; digits are derived only when observed.
    task automatic model_step(bit e, bit c, bit am, bit ah);
        int s, mn;
        bit tk, carry, hr;
        if (!rst_n || c) begin
            model_reset();
        end else begin
            tk = e && (m_presc == TD - 1);
            if (e) m_presc = (m_presc + 1) % TD;
            s  = m_secs % 60;
            mn = m_secs / 60;
            carry = tk && (s == 59);
            hr = 0;
            if (tk) s = (s + 1) % 60;
            if (carry || am) begin
                if (carry && mn == 59) hr = 1;
                mn = (mn + 1) % 60;
            end
            m_secs = mn * 60 + s;
            m_tick = tk;
            m_addh = hr || ah;
        end
    endtask

    task automatic cycle(bit e, bit c, bit am, bit ah);
        en = e; clear = c; adj_min = am; adj_hour = ah;
        model_step(e, c, am, ah);
        @(posedge clk);
        exp_q.push_back(model_obs());
        #1;
    endtask

    task automatic goto_tick(int target);
        int g = 0;
        while (!(m_secs == target && m_presc == TD - 1) && g < 20000) begin
            cycle(1, 0, 0, 0);
            g++;
        end
    endtask

    always @(negedge clk) begin
        obs_t e_obs;
        if (exp_q.size() != 0) begin
            e_obs = exp_q.pop_front();
            check("scoreboard", dut_obs(), e_obs);
        end
    end

    initial begin
        #7;
        check("reset_hold", dut_obs(), mk(0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        repeat (100) cycle(0, 0, 0, 0);

        repeat (40) cycle(1, 0, 0, 0);
        check("sec_10", dut_obs(), mk(1, 0, 0, 0, 1, 0));

        cycle(0, 1, 0, 0);
        repeat (12) cycle(0, 0, 1, 0);
        goto_tick(12 * 60 + 33);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        check("adj_min_1234", dut_obs(), mk(3, 4, 1, 3, 0, 0));

        cycle(0, 1, 0, 0);
        repeat (59) cycle(0, 0, 1, 0);
        goto_tick(59 * 60 + 19);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        check("adj_min_5920", dut_obs(), mk(2, 0, 0, 0, 0, 0));

        cycle(0, 1, 0, 0);
        repeat (58) cycle(0, 0, 1, 0);
        goto_tick(58 * 60 + 59);
        cycle(1, 0, 1, 0);
        check("adj_min_with_carry", dut_obs(), mk(0, 0, 5, 9, 1, 0));

        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        repeat (59) cycle(0, 0, 1, 0);
        goto_tick(3599);
        cycle(1, 0, 0, 1);
        check("adj_hour_at_rollover", dut_obs(), mk(0, 0, 0, 0, 1, 1));
        cycle(1, 0, 0, 0);

        cycle(0, 1, 0, 0);
        for (int i = 0; i < 3600 * TD + 60; i++) cycle(i < 7000 || i >= 7050, 0, 0, 0);

        cycle(0, 1, 0, 0);
        repeat (37) cycle(0, 0, 1, 0);
        goto_tick(37 * 60 + 41);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 1);
        check("clear_3742", dut_obs(), mk(0, 0, 0, 0, 0, 0));

        repeat (3000) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0,
                            $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);

        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_obs(), mk(0, 0, 0, 0, 0, 0));
        model_reset();
        repeat (2) cycle(1, 0, 1, 1);
        rst_n = 1'b1;
        repeat (500) cycle($urandom_range(0, 3) != 0, 0,
                           $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);

        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
